// File: rtl/ccc_cfg_pkg.sv
// rtl/ccc_cfg_pkg.sv - shared CCC reconfiguration types and defaults
package ccc_cfg_pkg;

  localparam int CCC_ADDR_W      = 6;
  localparam int CCC_DATA_W      = 8;
  localparam int CCC_SETTLE_CYC  = 16;
  localparam int CCC_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BUSY = 3'd1,
    ST_SETUP     = 3'd2,
    ST_ACCESS    = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_WAIT_LOCK = 3'd5,
    ST_RESP      = 3'd6
  } state_t;

endpackage

// File: rtl/cdc_sync2.sv
// rtl/cdc_sync2.sv - two-flop synchroniser, resets to 0
module cdc_sync2 (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the asynchronous input through two flops
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ccc_apb_reconfig_master.sv
// rtl/ccc_apb_reconfig_master.sv - APB initiator for the CCC dynamic-reconfiguration port
module ccc_apb_reconfig_master
  import ccc_cfg_pkg::*;
#(
  parameter int ADDR_W      = CCC_ADDR_W,
  parameter int DATA_W      = CCC_DATA_W,
  parameter int SETTLE_CYC  = CCC_SETTLE_CYC,
  parameter int TIMEOUT_CYC = CCC_TIMEOUT_CYC
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_relock,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              CCC_BUSY,
  input  logic              CCC_LOCK,
  output logic              lock_lost
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              write_q, relock_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              lock_s, lock_d;
  logic              accept, busy_timeout, lock_timeout, apb_active;

  cdc_sync2 u_lock_sync (
    .clk    (PCLK),
    .resetn (PRESET_N),
    .d      (CCC_LOCK),
    .q      (lock_s)
  );

  // state register
  always_ff @(posedge PCLK) begin
    if (!PRESET_N) state <= ST_IDLE;
    else           state <= state_n;
  end

  // next-state decode and APB/handshake outputs
  always_comb begin
    state_n      = state;
    req_ready    = (state == ST_IDLE) && ready_q;
    accept       = req_ready && req_valid;
    busy_timeout = 1'b0;
    lock_timeout = 1'b0;
    apb_active   = (state == ST_SETUP) || (state == ST_ACCESS);
    PSEL         = apb_active;
    PENABLE      = (state == ST_ACCESS);
    PWRITE       = apb_active && write_q;
    PADDR        = apb_active ? addr_q : '0;
    PWDATA       = (apb_active && write_q) ? wdata_q : '0;
    rsp_valid    = (state == ST_RESP);
    rsp_err      = (state == ST_RESP) && err_q;
    case (state)
      ST_IDLE: if (accept) state_n = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!CCC_BUSY) state_n = ST_SETUP;
        else if (cnt_q == CNT_MAX) begin
          state_n      = ST_RESP;
          busy_timeout = 1'b1;
        end
      end
      ST_SETUP:  state_n = ST_ACCESS;
      ST_ACCESS: state_n = relock_q ? ST_SETTLE : ST_RESP;
      ST_SETTLE: if (cnt_q == SETTLE_LAST) state_n = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) state_n = ST_RESP;
        else if (cnt_q == CNT_MAX) begin
          state_n      = ST_RESP;
          lock_timeout = 1'b1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // shared timeout/settle counter: clears on every state change, saturates
  always_ff @(posedge PCLK) begin
    if (!PRESET_N)               cnt_q <= '0;
    else if (state_n != state)   cnt_q <= '0;
    else if (cnt_q != CNT_MAX)   cnt_q <= cnt_q + CNT_W'(1);
  end

  // request latch, read capture and error flag
  always_ff @(posedge PCLK) begin
    if (!PRESET_N) begin
      ready_q  <= 1'b0;
      write_q  <= 1'b0;
      relock_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (accept) begin
        write_q  <= req_write;
        relock_q <= req_write && req_relock;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= 1'b0;
      end
      if (state == ST_ACCESS) rdata_q <= write_q ? '0 : PRDATA;
      if (busy_timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if (lock_timeout) err_q <= 1'b1;
    end
  end

  assign rsp_rdata = rdata_q;

  // sticky loss-of-lock seen while idle; a new fall beats the accept clear
  always_ff @(posedge PCLK) begin
    if (!PRESET_N) begin
      lock_d    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_d <= lock_s;
      if ((state == ST_IDLE) && lock_d && !lock_s) lock_lost <= 1'b1;
      else if (accept)                             lock_lost <= 1'b0;
    end
  end

endmodule
